// File: rtl/mem_wb_pipe_if.sv
// MEM->WB stage bundle: valid/ready handshake plus GPR and HI/LO write payload.
// master drives valid and payload and samples ready; slave does the reverse.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] wd;
  logic              wreg;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              whilo;

  modport master (
    output valid, wd, wreg, wdata,
    output hi, lo, whilo,
    input  ready
  );

  modport slave (
    input  valid, wd, wreg, wdata,
    input  hi, lo, whilo,
    output ready
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: 2-entry skid buffer, sync flush, transfer count.
// Ports: clk, rst (async, active low), flush, mem (slave), wb (master), xfer_cnt.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_pipe_if.slave     mem,
  mem_wb_pipe_if.master    wb,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } ent_t;

  ent_t             m_q, m_d;
  ent_t             s_q, s_d;
  ent_t             in_e;
  logic             m_v, m_v_d;
  logic             s_v, s_v_d;
  logic             acc, con;
  logic [CNT_W-1:0] cnt_d;

  assign acc = mem.valid && !s_v;
  assign con = m_v && wb.ready;

  always_comb begin
    in_e       = '0;
    in_e.wd    = mem.wd;
    in_e.wreg  = mem.wreg;
    in_e.wdata = mem.wdata;
    in_e.hi    = mem.hi;
    in_e.lo    = mem.lo;
    in_e.whilo = mem.whilo;
  end

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v;
    s_v_d = s_v;
    cnt_d = xfer_cnt;
    if (flush) begin
      m_d   = '0;
      s_d   = '0;
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else begin
      if (con) cnt_d = xfer_cnt + 1'b1;
      unique case (1'b1)
        !m_v: begin
          if (acc) begin
            m_d   = in_e;
            m_v_d = 1'b1;
          end
        end
        m_v && !s_v: begin
          if (acc && con) begin
            m_d = in_e;
          end else if (acc) begin
            s_d   = in_e;
            s_v_d = 1'b1;
          end else if (con) begin
            m_d   = '0;
            m_v_d = 1'b0;
          end
        end
        m_v && s_v: begin
          // skid drains into main; ready returns next cycle
          if (con) begin
            m_d   = s_q;
            s_d   = '0;
            s_v_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q      <= '0;
      s_q      <= '0;
      m_v      <= 1'b0;
      s_v      <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      m_q      <= m_d;
      s_q      <= s_d;
      m_v      <= m_v_d;
      s_v      <= s_v_d;
      xfer_cnt <= cnt_d;
    end
  end

  assign mem.ready = !s_v;
  assign wb.valid  = m_v;
  assign wb.wd     = m_q.wd;
  assign wb.wreg   = m_q.wreg && m_v;
  assign wb.wdata  = m_q.wdata;
  assign wb.hi     = m_q.hi;
  assign wb.lo     = m_q.lo;
  assign wb.whilo  = m_q.whilo && m_v;

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush and a transfer counter. It sits between the memory-access stage and the write-back stage and carries the GPR write (address, enable, data) and the HI/LO write (hi, lo, enable). The write-back stage can now stall without losing a beat, and invalid slots can never produce a register write.

## Interface
- DATA_W, 32: width of wdata, hi, lo.
- ADDR_W, 5: width of the destination register address.
- CNT_W, 32: width of the transfer counter.
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is synchronous to clk.
- flush  in  1  synchronous flush; discards all buffered entries.
- in_valid  in  1  the MEM stage presents an entry.
- in_ready  out  1  the block can accept an entry this cycle.
- mem_wd  in  ADDR_W  destination register address.
- mem_wreg  in  1  GPR write enable.
- mem_wdata  in  DATA_W  GPR write data.
- mem_hi, mem_lo  in  DATA_W  HI/LO write data.
- mem_whilo  in  1  HI/LO write enable.
- out_valid  out  1  the wb_* outputs carry a valid entry.
- out_ready  in  1  the WB stage consumes the entry this cycle.
- wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo  out  as the matching mem_* ports  head entry presented to write-back.
- xfer_cnt  out  CNT_W  number of completed output transfers.

## Operation
- Storage: a main entry (M) drives wb_*. A skid entry (S) holds overflow. Each entry has a valid bit: m_v, s_v.
- Accept: occurs when in_valid && in_ready. Consume: occurs when out_valid && out_ready.
- out_valid = m_v. in_ready = !s_v. in_ready comes from a register, with no combinational path from out_ready.
- wb_wreg = M.wreg && m_v. wb_whilo = M.whilo && m_v. An empty slot never writes.
- The other wb_* outputs show M payload bits as stored. M payload is zero whenever m_v = 0.
- The buffer holds 0, 1 or 2 entries. Per-cycle update:
  - Empty, accept: the entry goes to M.
  - M only; accept and consume: the new entry replaces M.
  - M only; accept, no consume: the entry goes to S, and in_ready drops next cycle.
  - M only; consume, no accept: m_v clears and M payload is zeroed.
  - M and S; consume: S moves to M, s_v clears and in_ready rises next cycle. No accept is possible while S is full.
  - Any state, neither event: hold.
- Order is strict FIFO: S is always younger than M.
- Flush takes priority over accept and consume:
  - m_v and s_v clear, and both payloads are zeroed.
  - An entry presented on the flush cycle is dropped.
  - A consume on the flush cycle is not counted.
- xfer_cnt increments by 1 per consume and wraps modulo 2^CNT_W. Flush does not clear it.
- Reset values:
  - out_valid = 0, in_ready = 1.
  - wb_wd = 0 (`NOPRegAddr`), wb_wreg = 0, wb_whilo = 0 (`WriteDisable`).
  - wb_wdata = wb_hi = wb_lo = 0 (`ZeroWord`).
  - xfer_cnt = 0, s_v = 0.

## Timing
- Latency: an entry accepted at edge N appears on wb_* with out_valid = 1 after edge N, when the buffer is empty or M is being consumed.
- Throughput is 1 entry per cycle while out_ready = 1.
- Full: after S fills at edge N, in_ready = 0 from edge N until the edge after the first consume.
- Refill: in_ready returns to 1 the cycle after S drains, so the bubble costs exactly 1 cycle.
- Flush asserted across edge N: out_valid = 0 and in_ready = 1 immediately after edge N.
- Reset mid-operation: all state clears asynchronously, and buffered entries are lost without being counted.
- in_valid and payload need not stay stable while in_ready = 0. Only the cycle of the accept matters.

## Test plan
- Reset, then stream 4 entries (wd = 1..4, wdata = 0xA1..0xA4, wreg = 1) with out_ready = 1 -> each appears 1 cycle after its accept, in order, with out_valid continuous; xfer_cnt = 4.
- Hold out_ready = 0 and present entries wd = 7, then wd = 8 -> in_ready = 0 after the second accept and out_valid = 1 holding wd = 7. Raise out_ready -> wd = 7, then wd = 8 are delivered; in_ready = 1 one cycle after S drains.
- Fill both entries, then pulse flush together with in_valid (wd = 9) and out_ready = 1 -> out_valid = 0, wb_wreg = wb_whilo = 0, wd = 9 is never output, and xfer_cnt is unchanged.
- Entry with whilo = 1, hi = 0xDEAD_BEEF, lo = 0x1234_5678, wreg = 0 -> wb_whilo = 1 with the matching hi/lo and wb_wreg = 0. After it is consumed with no new input -> wb_whilo = 0 and wb_hi = wb_lo = 0.
- Assert rst = 0 asynchronously mid-cycle while 2 entries are held -> all outputs reach their reset values before the next edge. Release rst -> the first accepted entry is output normally.
- With CNT_W = 3, perform 9 transfers -> xfer_cnt reads 7, then wraps to 0, then 1.
